// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory read bus between fetch_unit and memory
//   mem_addr  : read address, driven by the fetch unit
//   mem_rd    : read request, driven by the fetch unit
//   mem_ready : read data valid this cycle, driven by memory
//   mem_data  : read data, driven by memory
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ready,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ready,
        output mem_data
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register plus IDLE/BUSY/DONE memory read FSM
//   clk, rst_n            : clock, asynchronous active-low reset
//   fetch_en              : control unit requests a fetch
//   incr_pc, branch_en    : PC advance / PC load from branch_target (branch wins)
//   mem (fetch_unit_if)   : instruction-memory read bus, master side
//   instr, instr_valid    : latched instruction and its validity
//   pc                    : current program counter
//   needWait              : control unit must hold while a fetch is outstanding
//   fetch_err             : sticky read-timeout flag (FETCH_TIMEOUT_EN only)
// Optional feature macro: FETCH_TIMEOUT_EN adds the BUSY timeout counter and fetch_err.
module fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              incr_pc,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    fetch_unit_if.master      mem,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              needWait
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              fetch_err
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    // Remembers a branch seen during the current read so its result is not marked valid.
    logic              squash;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt;
`endif

    assign mem.mem_addr = addr_q;
    assign mem.mem_rd   = (state == BUSY);
    assign needWait     = fetch_en && (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RST;
        end else if (branch_en) begin
            pc <= branch_target;
        end else if (incr_pc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= PC_RST;
            instr       <= '0;
            instr_valid <= 1'b0;
            squash      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt         <= '0;
            fetch_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        addr_q      <= pc;
                        instr_valid <= 1'b0;
                        squash      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        cnt         <= '0;
`endif
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (branch_en) begin
                        squash <= 1'b1;
                    end
                    if (mem.mem_ready) begin
                        instr       <= mem.mem_data;
                        instr_valid <= ~squash;
                        state       <= DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // cnt holds the number of BUSY cycles already spent without data,
                    // so this fires on the TIMEOUT-th empty cycle and delivers a NOP.
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        instr       <= '0;
                        instr_valid <= ~squash;
                        fetch_err   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // A branch in any state invalidates the held instruction, overriding a capture.
            if (branch_en) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    typedef struct {
        int          delay;
        logic [15:0] data;
        bit          br;
        logic [15:0] tgt;
        bit          incr;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic        valid;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        incr_pc;
    logic        branch_en;
    logic [15:0] branch_target;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        needWait;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) mif ();

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(0), .TIMEOUT(255)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .incr_pc       (incr_pc),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .mem           (mif.master),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .needWait      (needWait)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err     (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] mpc;
    res_t        exp_q[$];
    res_t        obs_q[$];

    // Monitor: a completed read handshake is reported one half-cycle later with the latched result.
    logic        pend = 1'b0;
    logic [15:0] cap_addr;
    always @(negedge clk) begin
        if (pend) begin
            obs_q.push_back('{cap_addr, instr, instr_valid});
            pend = 1'b0;
        end
        if (mif.mem_rd && mif.mem_ready) begin
            cap_addr = mif.mem_addr;
            pend     = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_fetch(input vec_t v);
        int   rd_cnt;
        res_t e;
        res_t o;
        e.addr  = mpc;
        e.instr = v.data;
        e.valid = !v.br;
        exp_q.push_back(e);
        fetch_en = 1'b1;
        #1;
        chk("needwait_idle", 32'(needWait), 32'd1);
        @(posedge clk); #1;
        rd_cnt = 0;
        for (int i = 0; i <= v.delay; i++) begin
            if (i == v.delay) begin
                mif.mem_ready = 1'b1;
                mif.mem_data  = v.data;
            end
            if (i == 0 && v.br) begin
                branch_en     = 1'b1;
                incr_pc       = 1'b1;
                branch_target = v.tgt;
                mpc           = v.tgt;
            end
            #1;
            if (mif.mem_rd) rd_cnt++;
            chk("addr_stable", 32'(mif.mem_addr), 32'(e.addr));
            chk("needwait_busy", 32'(needWait), 32'd1);
            @(posedge clk); #1;
            branch_en     = 1'b0;
            incr_pc       = 1'b0;
            mif.mem_ready = 1'b0;
        end
        chk("busy_cycles", 32'(rd_cnt), 32'(v.delay + 1));
        if (v.incr) begin
            incr_pc = 1'b1;
            mpc     = mpc + 16'd1;
        end
        #1;
        chk("needwait_done", 32'(needWait), 32'd0);
        chk("rd_done", 32'(mif.mem_rd), 32'd0);
        @(posedge clk); #1;
        incr_pc  = 1'b0;
        fetch_en = 1'b0;
        chk("pc", 32'(pc), 32'(mpc));
        if (obs_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL no_result: got nothing expected addr %0h", e.addr);
            void'(exp_q.pop_front());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk("sb_addr", 32'(o.addr), 32'(e.addr));
            chk("sb_instr", 32'(o.instr), 32'(e.instr));
            chk("sb_valid", 32'(o.valid), 32'(e.valid));
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{5, 16'hBEEF, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{1, 16'h0A5A, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{0, 16'h1111, 1'b1, 16'h0040, 1'b0};
        vecs[4] = '{2, 16'h2222, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{3, 16'h3333, 1'b1, 16'hFFFF, 1'b1};
        vecs[6] = '{0, 16'h4444, 1'b0, 16'h0000, 1'b0};

        rst_n         = 1'b0;
        fetch_en      = 1'b0;
        incr_pc       = 1'b0;
        branch_en     = 1'b0;
        branch_target = 16'h0000;
        mif.mem_ready = 1'b0;
        mif.mem_data  = 16'h0000;
        mpc           = 16'h0000;

        #12;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_addr", 32'(mif.mem_addr), 32'h0);
        chk("rst_rd", 32'(mif.mem_rd), 32'd0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_needwait", 32'(needWait), 32'd0);
`ifdef FETCH_TIMEOUT_EN
        chk("rst_err", 32'(fetch_err), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            run_fetch(vecs[k]);
        end

        // mem_ready while idle must not touch instr
        mif.mem_ready = 1'b1;
        mif.mem_data  = 16'hDEAD;
        @(posedge clk); #1;
        chk("idle_ready_instr", 32'(instr), 32'h4444);
        chk("idle_ready_valid", 32'(instr_valid), 32'd1);
        chk("idle_ready_rd", 32'(mif.mem_rd), 32'd0);
        mif.mem_ready = 1'b0;

        // asynchronous reset in the middle of a read
        incr_pc = 1'b1;
        mpc     = mpc + 16'd1;
        @(posedge clk); #1;
        incr_pc  = 1'b0;
        chk("pre_abort_pc", 32'(pc), 32'(mpc));
        fetch_en = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_rd", 32'(mif.mem_rd), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rd", 32'(mif.mem_rd), 32'd0);
        chk("abort_pc", 32'(pc), 32'h0);
        chk("abort_instr", 32'(instr), 32'h0);
        chk("abort_valid", 32'(instr_valid), 32'd0);
        mpc = 16'h0000;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        fetch_en = 1'b0;
        run_fetch('{1, 16'h5555, 1'b0, 16'h0000, 1'b0});

`ifdef FETCH_TIMEOUT_EN
        begin
            int rd_cnt;
            fetch_en = 1'b1;
            @(posedge clk); #1;
            rd_cnt = 0;
            while (mif.mem_rd && rd_cnt < 400) begin
                rd_cnt++;
                @(posedge clk); #1;
            end
            fetch_en = 1'b0;
            chk("to_cycles", 32'(rd_cnt), 32'd255);
            chk("to_instr", 32'(instr), 32'h0);
            chk("to_valid", 32'(instr_valid), 32'd1);
            chk("to_err", 32'(fetch_err), 32'd1);
            @(posedge clk); #1;
            run_fetch('{0, 16'h6666, 1'b0, 16'h0000, 1'b0});
            chk("to_err_sticky", 32'(fetch_err), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("to_err_cleared", 32'(fetch_err), 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
